audio_gain_ramp: RTL and testbench
==================================

# audio_gain_ramp

Stereo gain stage placed directly downstream of the 2-channel IIR low-pass filter in the audio output path. It consumes the filter's signed 16-bit left/right samples on each output-rate strobe and applies a linear gain that ramps smoothly toward a target value, so volume changes and muting produce no zipper noise. A single time-shared multiplier serves both channels. The stage also provides per-channel peak meters and a sticky overrun flag.

## Interface
- RAMP_DIV, 16: number of accepted samples per ±1 gain step (1..65535)
- INIT_GAIN, 0: gain_cur value after reset (0..256); 0 gives a fade-in from silence

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- sample_ce  in  1  one-cycle strobe; input_l/input_r valid in the same cycle
- input_l, input_r  in  16  signed samples from the filter output
- gain  in  9  unsigned target gain; 256 = unity; values above 256 clamp to 256
- mute  in  1  forces the effective target to 0 while high
- peak_clr  in  1  one-cycle strobe that clears both peak registers
- output_l, output_r  out  16  signed scaled samples
- out_ce  out  1  one-cycle strobe marking new output values
- gain_cur  out  9  current applied gain
- mute_done  out  1  high while mute=1 and gain_cur=0
- peak_l, peak_r  out  15  maximum |output| since the last clear
- overrun  out  1  sticky; a sample_ce arrived while busy

## Operation
- FSM states: IDLE, MUL_L, MUL_R, DONE.
- **IDLE:** on sample_ce, latch input_l, input_r and gain_cur into holding registers, then go to MUL_L.
- **MUL_L:** compute p = signed(in_l) × {0, gain_hold}, giving a 26-bit signed product. res_l = p[23:8] (arithmetic shift right by 8, truncation toward −inf). Go to MUL_R.
- **MUL_R:** same computation for the right channel. Go to DONE.
- **DONE:**
  - Load output_l/output_r and pulse out_ce.
  - Update the peaks and the ramp.
  - Return to IDLE.
- No saturation is needed, because gain ≤ 256 gives |res| ≤ |in|.
- At gain 256 the output equals the input bit-exactly. At gain 0 the output is 0.
- Effective target: tgt = mute ? 0 : min(gain, 256).
- Ramp: a 16-bit divider counter increments in DONE.
  - When the counter reaches RAMP_DIV−1, it wraps to 0 and gain_cur steps one unit toward tgt.
  - When gain_cur == tgt, no step occurs and the counter still runs.
  - A change in tgt mid-ramp redirects the ramp on the next step; no restart occurs.
- The gain applied to a sample is the gain_cur latched in IDLE. A ramp step taken in DONE affects the next sample only.
- Peak: a = |res|, with −32768 mapped to 32767. peak_x <= max(peak_x, a) in DONE.
- peak_clr:
  - In a non-DONE cycle, both peaks go to 0.
  - Coinciding with DONE, both peaks go to the new a instead (clear-then-update).
- Overrun: a sample_ce seen in MUL_L, MUL_R or DONE is dropped and sets overrun. overrun clears only on reset.
- mute_done is combinational from mute and gain_cur.

## Timing
- Reset values (async, immediate):
  - FSM = IDLE
  - output_l = output_r = 0
  - out_ce = 0
  - gain_cur = INIT_GAIN
  - divider = 0
  - peak_l = peak_r = 0
  - overrun = 0
- Latency: if sample_ce is high in cycle T, then output_l/output_r, peaks and gain_cur update and out_ce is high in cycle T+3. The new outputs are stable from T+3 until the next DONE.
- Minimum sample_ce spacing is 4 cycles. sample_ce in cycle T+4 is accepted; sample_ce in T+1..T+3 is dropped and sets overrun.
- out_ce is never high for two consecutive cycles.
- Reset asserted mid-computation aborts it: there is no out_ce pulse for the aborted sample, and all registers take their reset values.
- The gain, mute and peak_clr inputs are synchronous to clk and need no handshake.

## Test plan
- **Unity passthrough:** INIT_GAIN=256, gain=256, input_l=0x7FFF, input_r=0x8000 → output_l=0x7FFF and output_r=0x8000, with out_ce high exactly 3 cycles after sample_ce.
- **Half gain and rounding:** gain=128, input_l=−3, input_r=5 → output_l=−2 (0xFFFE), output_r=2.
- **Ramp:** RAMP_DIV=2, INIT_GAIN=0, gain=4, 10 samples → gain_cur sequence after each DONE is 0,1,1,2,2,3,3,4,4,4. The first output uses gain 0.
- **Mute:** gain_cur=3, RAMP_DIV=1, assert mute → gain_cur goes 2,1,0 over 3 samples. mute_done rises in the DONE cycle where gain_cur reaches 0. Outputs are then 0 while inputs are non-zero.
- **Peak and overrun:** at unity, outputs −32768 then 100 → peak_l=32767. peak_clr coincident with the next DONE (output 50) → peak_l=50. A second sample_ce 2 cycles after the first → dropped, overrun=1, only one out_ce.
- **Reset mid-operation:** assert reset in the MUL_R cycle → no out_ce, outputs 0, gain_cur=INIT_GAIN. The next sample_ce after release is processed normally.

Source files
------------

// File: rtl/audio_gain_ramp_if.sv
// ============================================================================
// Module   : audio_gain_ramp_if
// Brief    : Sample, control and status bundle for the stereo gain ramp stage
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface audio_gain_ramp_if;
    logic        sample_ce;
    logic [15:0] input_l;
    logic [15:0] input_r;
    logic [8:0]  gain;
    logic        mute;
    logic        peak_clr;
    logic [15:0] output_l;
    logic [15:0] output_r;
    logic        out_ce;
    logic [8:0]  gain_cur;
    logic        mute_done;
    logic [14:0] peak_l;
    logic [14:0] peak_r;
    logic        overrun;

    modport master (
        output sample_ce, input_l, input_r, gain, mute, peak_clr,
        input  output_l, output_r, out_ce, gain_cur, mute_done,
               peak_l, peak_r, overrun
    );

    modport slave (
        input  sample_ce, input_l, input_r, gain, mute, peak_clr,
        output output_l, output_r, out_ce, gain_cur, mute_done,
               peak_l, peak_r, overrun
    );
endinterface

`default_nettype wire

// File: rtl/audio_gain_ramp.sv
// ============================================================================
// Module   : audio_gain_ramp
// Brief    : Stereo gain stage with zipper-free linear ramp, peak meters, overrun
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module audio_gain_ramp #(
    parameter int RAMP_DIV  = 16,
    parameter int INIT_GAIN = 0
) (
    input  logic              clk,
    input  logic              reset,
    audio_gain_ramp_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_L = 2'd1,
        MUL_R = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [8:0]  c_init_gain = 9'(INIT_GAIN);
    localparam logic [8:0]  c_unity     = 9'd256;
    localparam logic [15:0] c_div_last  = 16'(RAMP_DIV - 1);

    state_t r_state, w_state_nxt;

    logic [15:0] r_in_l, r_in_r, r_res_l;
    logic [8:0]  r_gain_hold, r_gain_cur;
    logic [15:0] r_output_l, r_output_r;
    logic        r_out_ce, r_overrun;
    logic [15:0] r_div;
    logic [14:0] r_peak_l, r_peak_r;

    logic signed [25:0] w_op_a, w_op_b, w_prod;
    logic [15:0]        w_mul_in, w_res;
    logic [8:0]         w_tgt;
    logic [14:0]        w_mag_l, w_mag_r;
    logic               w_writeback;

    function automatic logic [14:0] f_mag(input logic [15:0] v);
        if (v == 16'h8000)
            return 15'h7FFF;
        else if (v[15])
            return 15'(-v);
        else
            return v[14:0];
    endfunction

    // One multiplier shared by both channels; the operand follows the state.
    assign w_mul_in = (r_state == MUL_R) ? r_in_r : r_in_l;
    assign w_op_a   = {{10{w_mul_in[15]}}, w_mul_in};
    assign w_op_b   = {17'd0, r_gain_hold};
    assign w_prod   = w_op_a * w_op_b;
    assign w_res    = 16'(w_prod >>> 8);

    assign w_tgt = bus.mute ? 9'd0 : ((bus.gain > c_unity) ? c_unity : bus.gain);

    // Results are registered on the edge into DONE so they are visible during DONE.
    assign w_writeback = (r_state == MUL_R);

    assign w_mag_l = (r_state == DONE) ? f_mag(r_output_l) : f_mag(r_res_l);
    assign w_mag_r = (r_state == DONE) ? f_mag(r_output_r) : f_mag(w_res);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.sample_ce) w_state_nxt = MUL_L;
            MUL_L:   w_state_nxt = MUL_R;
            MUL_R:   w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_in_l      <= '0;
            r_in_r      <= '0;
            r_res_l     <= '0;
            r_gain_hold <= '0;
            r_gain_cur  <= c_init_gain;
            r_output_l  <= '0;
            r_output_r  <= '0;
            r_out_ce    <= 1'b0;
            r_overrun   <= 1'b0;
            r_div       <= '0;
            r_peak_l    <= '0;
            r_peak_r    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_out_ce <= w_writeback;

            if (r_state == IDLE && bus.sample_ce) begin
                r_in_l      <= bus.input_l;
                r_in_r      <= bus.input_r;
                r_gain_hold <= r_gain_cur;
            end
            if (r_state != IDLE && bus.sample_ce)
                r_overrun <= 1'b1;

            if (r_state == MUL_L)
                r_res_l <= w_res;

            if (w_writeback) begin
                r_output_l <= r_res_l;
                r_output_r <= w_res;
                if (r_div == c_div_last) begin
                    r_div <= '0;
                    if (r_gain_cur < w_tgt)
                        r_gain_cur <= r_gain_cur + 9'd1;
                    else if (r_gain_cur > w_tgt)
                        r_gain_cur <= r_gain_cur - 9'd1;
                end else begin
                    r_div <= r_div + 16'd1;
                end
            end

            // A clear around the write-back leaves only the current sample in the meters.
            if (bus.peak_clr) begin
                r_peak_l <= (w_writeback || r_state == DONE) ? w_mag_l : 15'd0;
                r_peak_r <= (w_writeback || r_state == DONE) ? w_mag_r : 15'd0;
            end else if (w_writeback) begin
                if (w_mag_l > r_peak_l) r_peak_l <= w_mag_l;
                if (w_mag_r > r_peak_r) r_peak_r <= w_mag_r;
            end
        end
    end

    assign bus.output_l  = r_output_l;
    assign bus.output_r  = r_output_r;
    assign bus.out_ce    = r_out_ce;
    assign bus.gain_cur  = r_gain_cur;
    assign bus.mute_done = bus.mute && (r_gain_cur == 9'd0);
    assign bus.peak_l    = r_peak_l;
    assign bus.peak_r    = r_peak_r;
    assign bus.overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_audio_gain_ramp.sv
// ============================================================================
// Module   : tb_audio_gain_ramp
// Brief    : Directed-vector bench for audio_gain_ramp (two parameterisations)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_audio_gain_ramp;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_ce;
    logic [15:0] in_l, in_r;
    logic [8:0]  gain;
    logic        mute, peak_clr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    audio_gain_ramp_if ia ();
    audio_gain_ramp_if ib ();

    assign ia.sample_ce = sample_ce;
    assign ia.input_l   = in_l;
    assign ia.input_r   = in_r;
    assign ia.gain      = gain;
    assign ia.mute      = mute;
    assign ia.peak_clr  = peak_clr;
    assign ib.sample_ce = sample_ce;
    assign ib.input_l   = in_l;
    assign ib.input_r   = in_r;
    assign ib.gain      = gain;
    assign ib.mute      = mute;
    assign ib.peak_clr  = peak_clr;

    // Instance A: unity start, one step per sample. Instance B: fade-in, step every 2.
    audio_gain_ramp #(.RAMP_DIV(1), .INIT_GAIN(256)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ia.slave)
    );

    audio_gain_ramp #(.RAMP_DIV(2), .INIT_GAIN(0)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ib.slave)
    );

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns at the negedge inside the cycle where out_ce is high.
    task automatic run_sample(input logic [15:0] l, input logic [15:0] r);
        int lat;
        @(negedge clk);
        sample_ce = 1'b1;
        in_l      = l;
        in_r      = r;
        @(negedge clk);
        sample_ce = 1'b0;
        lat       = 1;
        while (!ia.out_ce && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 3);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int ramp_exp [10] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 4};

        reset     = 1'b1;
        sample_ce = 1'b0;
        in_l      = '0;
        in_r      = '0;
        gain      = 9'd256;
        mute      = 1'b0;
        peak_clr  = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_gain_a", ia.gain_cur, 256);
        check("rst_gain_b", ib.gain_cur, 0);
        check("rst_out_l",  sx(ia.output_l), 0);
        check("rst_out_ce", ia.out_ce, 0);
        check("rst_peak_l", ia.peak_l, 0);
        check("rst_ovr",    ia.overrun, 0);
        reset = 1'b0;

        // Unity passthrough and peak metering
        run_sample(16'h7FFF, 16'h8000);
        check("unity_l", sx(ia.output_l), 32767);
        check("unity_r", sx(ia.output_r), -32768);
        check("peak_l0", ia.peak_l, 32767);
        check("peak_r0", ia.peak_r, 32767);
        run_sample(16'h8000, 16'h0000);
        check("min_l",   sx(ia.output_l), -32768);
        check("peak_l1", ia.peak_l, 32767);
        run_sample(16'd100, 16'h0000);
        check("peak_l2", ia.peak_l, 32767);
        run_sample(16'd50, 16'h0000);
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        check("peak_clr_done_l", ia.peak_l, 50);
        check("peak_clr_done_r", ia.peak_r, 0);
        @(negedge clk);
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        check("peak_clr_idle", ia.peak_l, 0);

        // Overrun: second strobe two cycles after the first
        check("ovr_before", ia.overrun, 0);
        @(negedge clk);
        sample_ce = 1'b1;
        in_l      = 16'd7;
        @(negedge clk);
        sample_ce = 1'b0;
        @(negedge clk);
        sample_ce = 1'b1;
        @(negedge clk);
        sample_ce = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (ia.out_ce) cnt++;
            @(negedge clk);
        end
        check("ovr_one_out_ce", cnt, 1);
        check("ovr_flag", ia.overrun, 1);

        // Ramp on instance B
        pulse_reset();
        gain = 9'd4;
        for (int i = 0; i < 10; i++) begin
            run_sample(16'd1000, 16'hFC18);
            if (i == 0) check("ramp_first_out", sx(ib.output_l), 0);
            check("ramp_gain", ib.gain_cur, ramp_exp[i]);
        end

        // Half gain: walk A from 256 down to 128
        pulse_reset();
        gain = 9'd128;
        repeat (128) run_sample(16'h0000, 16'h0000);
        check("half_gain", ia.gain_cur, 128);
        run_sample(16'hFFFD, 16'd5);
        check("half_l", sx(ia.output_l), -2);
        check("half_r", sx(ia.output_r), 2);

        // Mute ramp-down from 3
        gain = 9'd3;
        repeat (125) run_sample(16'h0000, 16'h0000);
        check("mute_start", ia.gain_cur, 3);
        check("mute_done0", ia.mute_done, 0);
        mute = 1'b1;
        run_sample(16'd1234, 16'd1234);
        check("mute_g2",  ia.gain_cur, 2);
        run_sample(16'd1234, 16'd1234);
        check("mute_g1",  ia.gain_cur, 1);
        check("mute_done1", ia.mute_done, 0);
        run_sample(16'd1234, 16'd1234);
        check("mute_g0",  ia.gain_cur, 0);
        check("mute_done2", ia.mute_done, 1);
        check("mute_out_g1", sx(ia.output_l), 4);
        run_sample(16'd1234, 16'hFB2E);
        check("mute_out_l", sx(ia.output_l), 0);
        check("mute_out_r", sx(ia.output_r), 0);

        // Reset during MUL_R
        mute = 1'b0;
        gain = 9'd256;
        run_sample(16'd1000, 16'd1000);
        check("pre_rst_gain", ia.gain_cur, 1);
        @(negedge clk);
        sample_ce = 1'b1;
        in_l      = 16'h1000;
        in_r      = 16'h1000;
        @(negedge clk);
        sample_ce = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cnt   = 0;
        repeat (4) begin
            @(negedge clk);
            if (ia.out_ce) cnt++;
        end
        check("rst_mid_no_out_ce", cnt, 0);
        check("rst_mid_out_l", sx(ia.output_l), 0);
        check("rst_mid_gain_a", ia.gain_cur, 256);
        check("rst_mid_gain_b", ib.gain_cur, 0);
        check("rst_mid_peak",   ia.peak_l, 0);
        reset = 1'b0;
        run_sample(16'h1000, 16'hF000);
        check("post_rst_l", sx(ia.output_l), 4096);
        check("post_rst_r", sx(ia.output_r), -4096);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
